// File: rtl/sram_64x15_req_ctrl.sv
// Request/response front-end for a single-port bit-masked SRAM: zero-fills the array
// after reset, then turns valid/ready requests into SRAM cycles with an in-order read FIFO.
module sram_64x15_req_ctrl #(
    parameter int BITS          = 15,
    parameter int WORD_DEPTH    = 64,
    parameter int ADDR_WIDTH    = 6,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_v_in,
    output logic                  req_ready_out,
    input  logic                  req_we_in,
    input  logic [ADDR_WIDTH-1:0] req_addr_in,
    input  logic [BITS-1:0]       req_data_in,
    input  logic [BITS-1:0]       req_mask_in,
    output logic                  resp_v_out,
    input  logic                  resp_ready_in,
    output logic [BITS-1:0]       resp_data_out,
    output logic                  init_done_out,
    output logic                  sram_ce_out,
    output logic                  sram_we_out,
    output logic [ADDR_WIDTH-1:0] sram_addr_out,
    output logic [BITS-1:0]       sram_wd_out,
    output logic [BITS-1:0]       sram_w_mask_out,
    input  logic [BITS-1:0]       sram_rd_in
);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    localparam state_e                RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(WORD_DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            occ_q, occ_d;
    logic                  wr_ptr_q, rd_ptr_q;
    logic [BITS-1:0]       fifo_q [2];

    logic                  push, pop, accept;
    logic [2:0]            pending;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        inflight_d      = 1'b0;
        pop             = 1'b0;
        accept          = 1'b0;
        push            = inflight_q;
        pending         = {1'b0, occ_q} + {2'b00, inflight_q};
        req_ready_out   = 1'b0;
        resp_v_out      = 1'b0;
        resp_data_out   = '0;
        init_done_out   = 1'b0;
        sram_ce_out     = 1'b0;
        sram_we_out     = 1'b0;
        sram_addr_out   = '0;
        sram_wd_out     = '0;
        sram_w_mask_out = '0;

        if (state_q == ST_INIT) begin
            sram_ce_out     = 1'b1;
            sram_we_out     = 1'b1;
            sram_addr_out   = cnt_q;
            sram_w_mask_out = '1;
            // Hold the counter on the last word so it never wraps.
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            init_done_out = 1'b1;
            resp_v_out    = (occ_q != 2'd0);
            resp_data_out = fifo_q[rd_ptr_q];
            pop           = resp_v_out & resp_ready_in;
            // Count the in-flight read as occupied so the FIFO can never overflow,
            // but credit a same-cycle pop to keep full read throughput.
            req_ready_out = (pending < (3'd2 + {2'b00, pop}));
            accept        = req_v_in & req_ready_out;
            inflight_d    = accept & ~req_we_in;
            if (accept) begin
                sram_ce_out     = 1'b1;
                sram_we_out     = req_we_in;
                sram_addr_out   = req_addr_in;
                sram_wd_out     = req_data_in;
                sram_w_mask_out = req_mask_in;
            end
        end

        occ_d = occ_q + {1'b0, push} - {1'b0, pop};

        if (!rst_n) begin
            req_ready_out   = 1'b0;
            resp_v_out      = 1'b0;
            resp_data_out   = '0;
            init_done_out   = 1'b0;
            sram_ce_out     = 1'b0;
            sram_we_out     = 1'b0;
            sram_addr_out   = '0;
            sram_wd_out     = '0;
            sram_w_mask_out = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RESET_STATE;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= sram_rd_in;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: doc/sram_64x15_req_ctrl.md
SRAM_64X15_REQ_CTRL -- requirements
Module: sram_64x15_req_ctrl

Interface
REQ-001 Parameters SHALL be: BITS, default 15, data and mask width; WORD_DEPTH, default 64, number of words; ADDR_WIDTH, default 6, address width; INIT_ON_RESET, default 1, zero-fill the SRAM after reset.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_v_in  input  1  request valid.
REQ-005 req_ready_out  output  1  request accepted when req_v_in & req_ready_out.
REQ-006 req_we_in  input  1  1 = write, 0 = read.
REQ-007 req_addr_in  input  ADDR_WIDTH  word address.
REQ-008 req_data_in  input  BITS  write data.
REQ-009 req_mask_in  input  BITS  per-bit write enable, 1 = write the bit.
REQ-010 resp_v_out  output  1  read data valid.
REQ-011 resp_ready_in  input  1  response consumed when resp_v_out & resp_ready_in.
REQ-012 resp_data_out  output  BITS  read data.
REQ-013 init_done_out  output  1  zero-fill complete; high while in RUN.
REQ-014 sram_ce_out  output  1  SRAM chip enable.
REQ-015 sram_we_out  output  1  SRAM write enable.
REQ-016 sram_addr_out  output  ADDR_WIDTH  SRAM address.
REQ-017 sram_wd_out  output  BITS  SRAM write data.
REQ-018 sram_w_mask_out  output  BITS  SRAM bit mask.
REQ-019 sram_rd_in  input  BITS  SRAM read data, valid the cycle after a read with ce=1, we=0.

Function
REQ-020 The FSM SHALL have two states: INIT and RUN. Reset enters INIT if INIT_ON_RESET=1, else RUN.
REQ-021 INIT SHALL sweep a 6-bit counter 0..WORD_DEPTH-1, one word per cycle: ce=1, we=1, mask all-ones, wd=0, addr=counter.
REQ-022 After writing address WORD_DEPTH-1, INIT SHALL go to RUN on the next edge; fill takes exactly 64 cycles; no counter wrap is allowed.
REQ-023 In INIT: req_ready_out=0, init_done_out=0, resp_v_out=0.
REQ-024 In RUN, the acceptance cycle SHALL drive the SRAM combinationally: ce=1, we=req_we_in, addr/wd/mask from the request fields.
REQ-025 Cycles without acceptance in RUN SHALL drive ce=0 and we=0; addr/wd/mask are don't-care.
REQ-026 A write SHALL produce no response.
REQ-027 An accepted read SHALL set an in-flight flag; the next cycle sram_rd_in SHALL be captured into a 2-entry in-order response FIFO.
REQ-028 Minimum read latency: response visible the cycle after capture, i.e. 2 cycles from acceptance.
REQ-029 req_ready_out SHALL equal RUN & (occupancy + inflight - pop < 2), where pop = resp_v_out & resp_ready_in; req_ready_out is independent of req_v_in and req_we_in.
REQ-030 The pop-aware ready SHALL sustain one read per cycle with resp_ready_in held high.
REQ-031 While resp_v_out=1 and resp_ready_in=0, resp_data_out SHALL hold stable.
REQ-032 FIFO push and pop in the same cycle SHALL leave occupancy unchanged and preserve order.
REQ-033 The FIFO SHALL never overflow; overflow is unreachable by REQ-029.
REQ-034 A read at address A the cycle after a write to A SHALL return the merged data: masked bits new, unmasked bits old.
REQ-035 Responses SHALL return in request order.

Reset
REQ-036 While rst_n=0, all outputs SHALL be 0: req_ready_out, resp_v_out, resp_data_out, init_done_out, and all sram_* outputs.
REQ-037 Reset SHALL clear the FIFO, in-flight flag and INIT counter; in-flight reads are discarded.
REQ-038 Reset asserted mid-INIT or mid-RUN SHALL restart from REQ-020 on deassertion.
REQ-039 SRAM contents are not preserved semantically across reset when INIT_ON_RESET=1.

Verification
REQ-040 Release reset, INIT_ON_RESET=1 -> 64 cycles of ce=we=1 with addr 0..63, wd=0; init_done_out rises cycle 64; then read addr 37 -> resp_data_out=0.
REQ-041 Write addr 5 data 0x7FFF mask 0x7FFF, then write addr 5 data 0x0000 mask 0x00FF, then read addr 5 -> 0x7F00.
REQ-042 resp_ready_in=0, issue reads to addr 1, 2, 3 -> first two accepted, req_ready_out=0 on the third; raise resp_ready_in -> data 1, 2, 3 returned in order; resp_data_out stable while stalled.
REQ-043 resp_ready_in=1, back-to-back reads addr 0..9 -> req_ready_out stays 1; 10 responses on consecutive cycles starting 2 cycles after the first accept.
REQ-044 Write addr 9 data 0x1234 then read addr 9 on the next cycle -> 0x1234.
REQ-045 Assert rst_n=0 with 2 responses buffered and 1 read in flight -> outputs 0 immediately; after release, INIT replays and no stale response appears.
